// File: rtl/btn_debounce_pkg.sv
// Package: btn_debounce_pkg
//
// Shared definitions for the push-button debouncer.
// - state_t    : press/hold FSM states (S_IDLE, S_DOWN, S_LONG).
// - ms_to_cyc  : converts a duration in ms to a count of clk cycles.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DOWN = 2'd1,
        S_LONG = 2'd2
    } state_t;

    // Divide first so the intermediate product stays inside 32 bits for
    // realistic clock rates (125 MHz * 1000 ms would overflow otherwise).
    function automatic int ms_to_cyc(input int clk_freq, input int ms);
        return (clk_freq / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce_sync_bits.sv
// Module: btn_debounce_sync_bits
//
// Two-flop synchroniser for a bundle of independent asynchronous pins.
// Each bit is synchronised on its own; no coherency between bits is implied.
//
// Ports:
// - clk   in   1      Destination clock.
// - rst_n in   1      Reset, asynchronous assert, active low; clears both stages to 0.
// - d     in   WIDTH  Asynchronous inputs.
// - q     out  WIDTH  Synchronised outputs, two cycles of latency.
module btn_debounce_sync_bits #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/btn_debounce.sv
// Module: btn_debounce
//
// Turns a raw, bouncing push-button pin into a clean debounced level plus
// single-cycle press, release and long-press pulses in the clk domain.
// Pipeline: polarity normalisation -> 2-FF synchroniser -> debounce filter
// -> press/hold FSM with registered outputs.
//
// Ports:
// - clk         in   1  System clock.
// - rst_n       in   1  Reset, asynchronous assert, active low.
// - btn_in      in   1  Raw asynchronous pin.
// - btn_level   out  1  Debounced level, 1 = pressed.
// - btn_press   out  1  One-cycle pulse on debounced press.
// - btn_release out  1  One-cycle pulse on debounced release.
// - btn_long    out  1  One-cycle pulse when the hold reaches C_LONG_CYC cycles.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int C_CLK_FREQ    = 125000000,
    parameter int C_DEBOUNCE_MS = 20,
    parameter int C_LONG_MS     = 1000,
    parameter int C_ACTIVE_LOW  = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int C_DB_CYC   = ms_to_cyc(C_CLK_FREQ, C_DEBOUNCE_MS);
    localparam int C_LONG_CYC = ms_to_cyc(C_CLK_FREQ, C_LONG_MS);
    localparam int DB_W       = $clog2(C_DB_CYC);
    localparam int LONG_W     = $clog2(C_LONG_CYC);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(C_DB_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(C_LONG_CYC - 1);

    // ------------------------------------------------------------------
    // Polarity normalisation happens before the synchroniser so that the
    // synchroniser's reset value of 0 always means "released".
    // ------------------------------------------------------------------
    logic pin_norm;
    logic sync_q;

    assign pin_norm = (C_ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    btn_debounce_sync_bits #(
        .WIDTH (1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pin_norm),
        .q     (sync_q)
    );

    // ------------------------------------------------------------------
    // Debounce filter: the synchronised input must disagree with the
    // accepted level for C_DB_CYC consecutive cycles before it is taken.
    // Any agreement restarts the count, so the counter never wraps.
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
    logic            stable_reg, stable_next;

    always_comb begin
        db_cnt_next = db_cnt_reg;
        stable_next = stable_reg;
        if (sync_q == stable_reg) begin
            db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
            stable_next = sync_q;
            db_cnt_next = '0;
        end else begin
            db_cnt_next = db_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_reg <= '0;
            stable_reg <= 1'b0;
        end else begin
            db_cnt_reg <= db_cnt_next;
            stable_reg <= stable_next;
        end
    end

    // ------------------------------------------------------------------
    // Press/hold FSM. Outputs are registered, so every pulse and the level
    // appear one cycle after the stable level changes, in step with each
    // other. A release always takes priority over the long-press threshold.
    // ------------------------------------------------------------------
    state_t            state_reg, state_next;
    logic [LONG_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              press_reg, press_next;
    logic              release_reg, release_next;
    logic              long_reg, long_next;
    logic              level_reg;

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        press_next    = 1'b0;
        release_next  = 1'b0;
        long_next     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (stable_reg) begin
                    state_next    = S_DOWN;
                    hold_cnt_next = '0;
                    press_next    = 1'b1;
                end
            end
            S_DOWN: begin
                if (!stable_reg) begin
                    state_next   = S_IDLE;
                    release_next = 1'b1;
                end else if (hold_cnt_reg == LONG_LAST) begin
                    // Counter stays at the threshold: it is frozen in S_LONG.
                    state_next = S_LONG;
                    long_next  = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            S_LONG: begin
                if (!stable_reg) begin
                    state_next   = S_IDLE;
                    release_next = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            hold_cnt_reg <= '0;
            press_reg    <= 1'b0;
            release_reg  <= 1'b0;
            long_reg     <= 1'b0;
            level_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            press_reg    <= press_next;
            release_reg  <= release_next;
            long_reg     <= long_next;
            level_reg    <= stable_reg;
        end
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;
    assign btn_long    = long_reg;

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench: tb_btn_debounce
//
// Drives an active-high and an active-low instance with the same logical
// button activity and checks both, every cycle, against a behavioural model:
// the level is accepted once the pin has held a new value for DB consecutive
// samples; events are derived from changes of the accepted level and from
// the elapsed time since the press.
module tb_btn_debounce;

    localparam int F_HZ  = 10000;
    localparam int DB_MS = 2;
    localparam int LG_MS = 10;
    localparam int DB    = 20;
    localparam int LONG  = 100;
    localparam int LAT   = DB + 3;

    logic clk = 1'b0;
    logic rst_n;
    logic pin;
    logic btn_in_ah, btn_in_al;
    logic lvl_a, prs_a, rel_a, lng_a;
    logic lvl_b, prs_b, rel_b, lng_b;

    assign btn_in_ah = pin;
    assign btn_in_al = ~pin;

    btn_debounce #(
        .C_CLK_FREQ(F_HZ), .C_DEBOUNCE_MS(DB_MS), .C_LONG_MS(LG_MS), .C_ACTIVE_LOW(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in_ah),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_long(lng_a)
    );

    btn_debounce #(
        .C_CLK_FREQ(F_HZ), .C_DEBOUNCE_MS(DB_MS), .C_LONG_MS(LG_MS), .C_ACTIVE_LOW(1)
    ) u_dut_al (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in_al),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_long(lng_b)
    );

    always #5 clk = ~clk;

    // Counters and model state
    int n_assert = 0;
    int n_fail   = 0;
    int e;                 // edges since reset release
    bit hist [0:4095];     // pin value sampled at each edge
    bit stable_m, level_m, long_done;
    int press_edge;
    int press_cnt, rel_cnt, long_cnt;
    int dut_press_edge, dut_rel_edge, dut_long_edge;
    int c;

    function automatic bit samp(input int k);
        if (k < 1 || k > 4095) return 1'b0;
        return hist[k];
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, e);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit lv, input bit pr, input bit rl, input bit lg);
        check({tag, "_lvl_ah"}, lvl_a, lv);
        check({tag, "_prs_ah"}, prs_a, pr);
        check({tag, "_rel_ah"}, rel_a, rl);
        check({tag, "_lng_ah"}, lng_a, lg);
        check({tag, "_lvl_al"}, lvl_b, lv);
        check({tag, "_prs_al"}, prs_b, pr);
        check({tag, "_rel_al"}, rel_b, rl);
        check({tag, "_lng_al"}, lng_b, lg);
    endtask

    task automatic model_reset();
        e = 0;
        stable_m = 1'b0;
        level_m = 1'b0;
        long_done = 1'b1;
        press_edge = 0;
    endtask

    task automatic clear_counts();
        press_cnt = 0; rel_cnt = 0; long_cnt = 0;
        dut_press_edge = -1; dut_rel_edge = -1; dut_long_edge = -1;
    endtask

    // One clock: record the pin, advance the model, compare both DUTs.
    task automatic step();
        bit p, x_lvl, x_prs, x_rel, x_lng, all_diff;
        p = pin;
        @(posedge clk);
        e++;
        if (e <= 4095) hist[e] = p;
        #1;
        x_lvl = stable_m;
        x_prs = stable_m && !level_m;
        x_rel = !stable_m && level_m;
        x_lng = stable_m && level_m && !long_done && ((e - press_edge) == LONG);
        if (x_prs) begin press_edge = e; long_done = 1'b0; end
        if (x_lng) long_done = 1'b1;
        level_m = x_lvl;
        // The synchronised sample seen at edge e is the pin sampled at edge e-2.
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++)
            if (samp(e - 2 - j) == stable_m) all_diff = 1'b0;
        if (all_diff) stable_m = !stable_m;
        check_all("cyc", x_lvl, x_prs, x_rel, x_lng);
        if (prs_a) begin press_cnt++; dut_press_edge = e; end
        if (rel_a) begin rel_cnt++; dut_rel_edge = e; end
        if (lng_a) begin long_cnt++; dut_long_edge = e; end
    endtask

    initial begin
        rst_n = 1'b0;
        pin = 1'b0;
        model_reset();
        clear_counts();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        repeat (5) step();

        // Clean press held 50 cycles
        clear_counts();
        c = e; pin = 1'b1;
        repeat (50) step();
        pin = 1'b0;
        repeat (30) step();
        check_int("clean_press_cnt", press_cnt, 1);
        check_int("clean_press_lat", dut_press_edge - c, LAT);
        check_int("clean_long_cnt", long_cnt, 0);
        check_int("clean_rel_lat", dut_rel_edge - (c + 50), LAT);

        // Bounce: 5 toggles of 3..10 cycles, final level high
        clear_counts();
        for (int t = 0; t < 4; t++) begin
            pin = ~pin;
            repeat ($urandom_range(3, 10)) step();
        end
        pin = 1'b1;
        c = e;
        repeat (40) step();
        check_int("bounce_press_cnt", press_cnt, 1);
        check_int("bounce_press_lat", dut_press_edge - c, LAT);
        pin = 1'b0;
        repeat (30) step();

        // Lone 15-cycle glitch
        clear_counts();
        pin = 1'b1;
        repeat (15) step();
        pin = 1'b0;
        repeat (30) step();
        check_int("glitch_press_cnt", press_cnt, 0);
        check_int("glitch_rel_cnt", rel_cnt, 0);

        // Long press held 150 cycles
        clear_counts();
        pin = 1'b1;
        repeat (150) step();
        pin = 1'b0;
        repeat (30) step();
        check_int("long_cnt", long_cnt, 1);
        check_int("long_after_press", dut_long_edge - dut_press_edge, LONG);
        check_int("long_rel_cnt", rel_cnt, 1);

        // Release landing on the long threshold: release only
        clear_counts();
        pin = 1'b1;
        repeat (100) step();
        pin = 1'b0;
        repeat (30) step();
        check_int("edge_long_cnt", long_cnt, 0);
        check_int("edge_rel_cnt", rel_cnt, 1);
        check_int("edge_rel_after_press", dut_rel_edge - dut_press_edge, LONG);

        // Reset while in the long-held state, pin still pressed
        clear_counts();
        pin = 1'b1;
        repeat (140) step();
        check_int("pre_reset_long_cnt", long_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_all("in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        model_reset();
        clear_counts();
        repeat (30) step();
        check_int("post_rst_press_cnt", press_cnt, 1);
        check_int("post_rst_press_lat", dut_press_edge, LAT);
        pin = 1'b0;
        repeat (30) step();

        // Random activity against the model
        for (int r = 0; r < 14; r++) begin
            pin = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 45)) step();
        end
        pin = 1'b0;
        repeat (30) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
